// File: rtl/xbox_mem_arb_pkg.sv
// Shared types and constants for the XBOX memory arbiter slice.
// A memory line is 8 x 32-bit words with one byte enable per byte.
package xbox_mem_arb_pkg;

  localparam int LINE_W    = 256;
  localparam int BE_W      = 32;
  localparam int NUM_WORDS = 8;
  localparam int WORD_W    = LINE_W / NUM_WORDS;

  localparam int ERR_COLLISION = 0;
  localparam int ERR_TIMEOUT   = 1;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BE_W-1:0]   be_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/xbox_mem_arb_if.sv
// Requester-side bus of the XBOX memory arbiter: per-master access inputs,
// one-hot grant/rvalid back, and the broadcast read line.
interface xbox_mem_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 4
);
  import xbox_mem_arb_pkg::*;

  logic [NUM_REQ-1:0][AW-1:0] req_addr;
  line_t [NUM_REQ-1:0]        req_wdata;
  be_t [NUM_REQ-1:0]          req_be;
  logic [NUM_REQ-1:0]         req_rd;
  logic [NUM_REQ-1:0]         req_wr;
  logic [NUM_REQ-1:0]         req_lock;
  logic [NUM_REQ-1:0]         req_gnt;
  line_t                      req_rdata;
  logic [NUM_REQ-1:0]         req_rvalid;

  modport master (
    output req_addr, req_wdata, req_be, req_rd, req_wr, req_lock,
    input  req_gnt, req_rdata, req_rvalid
  );

  modport slave (
    input  req_addr, req_wdata, req_be, req_rd, req_wr, req_lock,
    output req_gnt, req_rdata, req_rvalid
  );

endinterface

// File: rtl/xbox_mem_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr+1 (wrapping), returned both one-hot and as an index.
module xbox_mem_arb_rr_pick #(
  parameter  int N   = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id,
  output logic           valid
);

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    id    = '0;
    valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        gnt[idx] = 1'b1;
        id       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/xbox_mem_arb.sv
// Round-robin arbiter sharing one XBOX memory port between NUM_REQ masters,
// with locked bursts bounded by a watchdog and sticky error flags.
module xbox_mem_arb
  import xbox_mem_arb_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int LOCK_TIMEOUT       = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  xbox_mem_arb_if.slave                 bus,
  output logic [LOG2_LINES_PER_MEM-1:0] mem_addr,
  output line_t                         mem_wdata,
  output be_t                           mem_be,
  output logic                          mem_rd,
  output logic                          mem_wr,
  input  line_t                         mem_rdata,
  input  logic                          err_clr,
  output logic [1:0]                    err_status
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [1:0]         err_q, err_d;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_id;
  logic               pick_valid;
  logic               timed_out;
  logic               owner_keeps;
  logic               gnt_valid;
  logic [IDW-1:0]     gnt_id;
  logic [NUM_REQ-1:0] gnt_sel;

  assign active = bus.req_rd | bus.req_wr;

  xbox_mem_arb_rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (active),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // The owner keeps the port while it holds lock; an access it presents with
  // lock dropped is its final locked access. Otherwise fall back to round-robin.
  always_comb begin
    timed_out   = (cnt_q >= CNTW'(LOCK_TIMEOUT));
    owner_keeps = (state_q == LOCKED) && !timed_out &&
                  (bus.req_lock[owner_q] || active[owner_q]);
    gnt_valid   = 1'b0;
    gnt_id      = '0;
    gnt_sel     = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    if (rst_n) begin
      if (owner_keeps) begin
        gnt_valid = active[owner_q];
        gnt_id    = owner_q;
      end else begin
        gnt_valid = pick_valid;
        gnt_id    = pick_id;
      end
      if (gnt_valid) begin
        gnt_sel[gnt_id] = 1'b1;
        mem_addr        = bus.req_addr[gnt_id];
        mem_wdata       = bus.req_wdata[gnt_id];
        mem_be          = bus.req_be[gnt_id];
        mem_wr          = bus.req_wr[gnt_id];
        mem_rd          = bus.req_rd[gnt_id] & ~bus.req_wr[gnt_id];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    rvalid_d = gnt_sel & {NUM_REQ{mem_rd}};
    err_d    = err_clr ? 2'b00 : err_q;
    if (gnt_valid && bus.req_rd[gnt_id] && bus.req_wr[gnt_id]) begin
      err_d[ERR_COLLISION] = 1'b1;
    end
    if (gnt_valid) begin
      rr_ptr_d = gnt_id;
    end
    if (state_q == LOCKED) begin
      cnt_d = cnt_q + CNTW'(1);
      if (timed_out) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        state_d            = ARB;
      end else if (!bus.req_lock[owner_q]) begin
        state_d = ARB;
      end
    end
    if (!owner_keeps && gnt_valid && bus.req_lock[gnt_id]) begin
      state_d = LOCKED;
      owner_d = gnt_id;
      cnt_d   = CNTW'(1);
    end else if (state_d == ARB) begin
      cnt_d = '0;
    end
  end

  assign bus.req_gnt    = gnt_sel;
  assign bus.req_rvalid = rvalid_q;
  assign bus.req_rdata  = mem_rdata;
  assign err_status     = err_q;

endmodule
